// File: rtl/mem_wb_pkg.sv
// Shared opcode/func3 encodings, FSM state type and access-legality helper for mem_wb_unit.
package mem_wb_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // Doubleword and unsigned-word forms only exist on a 64-bit datapath.
  function automatic logic access_legal(input logic is_store, input logic [2:0] func3,
                                        input logic is_rv64);
    logic ok;
    if (is_store) begin
      case (func3)
        F3_B, F3_H, F3_W: ok = 1'b1;
        F3_D:             ok = is_rv64;
        default:          ok = 1'b0;
      endcase
    end else begin
      case (func3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
        F3_WU, F3_D:                    ok = is_rv64;
        default:                        ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data extraction: selects the addressed bytes of a memory word and sign/zero extends them.
module load_align #(
  parameter int XLEN = 32,
  parameter int OW   = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [OW-1:0]   offset,
  input  logic [2:0]      func3,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted_s;
  logic [XLEN-1:0] left_s;
  int              pad_s;

  // Move the field to bit 0, push it to the top, then shift back arithmetically or logically.
  always_comb begin
    shifted_s = rdata >> {offset, 3'b000};
    case (func3[1:0])
      2'b00:   pad_s = XLEN - 8;
      2'b01:   pad_s = XLEN - 16;
      2'b10:   pad_s = XLEN - 32;
      default: pad_s = 0;
    endcase
    left_s = shifted_s << pad_s;
    if (func3[2]) begin
      data = left_s >> pad_s;
    end else begin
      data = $signed(left_s) >>> pad_s;
    end
  end

endmodule

// File: rtl/mem_wb_unit.sv
// Memory/writeback stage: accepts one instruction, performs its data access, writes back.
// Optional feature: define MEM_WB_MISALIGN_TRAP_EN to trap misaligned loads/stores.
module mem_wb_unit
  import mem_wb_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      func3,
  input  logic            wb_reg,
  input  logic [4:0]      rd_num,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] rs2_data,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_req_we,
  output logic [XLEN-1:0] dmem_req_addr,
  output logic [XLEN-1:0] dmem_req_wdata,
  output logic [NB-1:0]   dmem_req_be,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rsp_rdata,
  output logic            wb_enable,
  output logic [4:0]      wb_rd_num,
  output logic [XLEN-1:0] wb_rd_data,
  output logic            done
`ifdef MEM_WB_MISALIGN_TRAP_EN
  ,output logic           misalign
`endif
);

  localparam int   OW      = $clog2(NB);
  localparam logic IS_RV64 = (XLEN == 64);

  state_e          state_r, state_nxt_s;
  logic            in_ready_r, req_valid_r, req_we_r, wb_enable_r, done_r;
  logic            is_load_r, wb_cond_r;
  logic [2:0]      func3_r;
  logic [OW-1:0]   offset_r;
  logic [4:0]      rd_num_r;
  logic [XLEN-1:0] req_addr_r, req_wdata_r, wb_data_r;
  logic [NB-1:0]   req_be_r;

  logic            accept_s, is_store_s, is_mem_s, legal_s, trap_s, go_mem_s, wb_cond_s;
  logic [2:0]      lo_mask3_s;
  logic [OW-1:0]   lo_mask_s, raw_off_s, off_s;
  logic [NB-1:0]   size_be_s;
  logic [XLEN-1:0] wdata_s, load_data_s;

  // Decode the offered instruction; only consumed on the accept cycle.
  always_comb begin
    accept_s   = (state_r == ST_IDLE) && in_valid;
    is_store_s = (opcode == OP_STORE);
    is_mem_s   = (opcode == OP_LOAD) || is_store_s;
    legal_s    = access_legal(is_store_s, func3, IS_RV64);
    raw_off_s  = alu_out[OW-1:0];
    case (func3[1:0])
      2'b00: begin
        lo_mask3_s = 3'd0; size_be_s = NB'(8'h01); wdata_s = {NB{rs2_data[7:0]}};
      end
      2'b01: begin
        lo_mask3_s = 3'd1; size_be_s = NB'(8'h03); wdata_s = {(NB/2){rs2_data[15:0]}};
      end
      2'b10: begin
        lo_mask3_s = 3'd3; size_be_s = NB'(8'h0F); wdata_s = {(NB/4){rs2_data[31:0]}};
      end
      default: begin
        lo_mask3_s = 3'd7; size_be_s = NB'(8'hFF); wdata_s = rs2_data;
      end
    endcase
    lo_mask_s = lo_mask3_s[OW-1:0];
`ifdef MEM_WB_MISALIGN_TRAP_EN
    trap_s = is_mem_s && legal_s && ((raw_off_s & lo_mask_s) != {OW{1'b0}});
    off_s  = raw_off_s;
`else
    // Misaligned accesses are silently pulled down to their natural alignment.
    trap_s = 1'b0;
    off_s  = raw_off_s & ~lo_mask_s;
`endif
    go_mem_s  = is_mem_s && legal_s && !trap_s;
    wb_cond_s = wb_reg && (rd_num != 5'd0) && !is_store_s && legal_s && !trap_s;
    if (!is_mem_s) begin
      wb_cond_s = wb_reg && (rd_num != 5'd0);
    end else begin
      wb_cond_s = wb_cond_s;
    end
  end

  // Next-state logic for the IDLE/REQ/RSP/WB sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt_s = go_mem_s ? ST_REQ : ST_WB;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (dmem_req_ready) begin
          state_nxt_s = is_load_r ? ST_RSP : ST_WB;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_RSP: begin
        if (dmem_rsp_valid) begin
          state_nxt_s = ST_WB;
        end else begin
          state_nxt_s = ST_RSP;
        end
      end
      ST_WB:   state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, registered handshake/strobe outputs and latched transaction fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      req_valid_r <= 1'b0;
      req_we_r    <= 1'b0;
      wb_enable_r <= 1'b0;
      done_r      <= 1'b0;
      is_load_r   <= 1'b0;
      wb_cond_r   <= 1'b0;
      func3_r     <= 3'd0;
      offset_r    <= {OW{1'b0}};
      rd_num_r    <= 5'd0;
      req_addr_r  <= {XLEN{1'b0}};
      req_wdata_r <= {XLEN{1'b0}};
      req_be_r    <= {NB{1'b0}};
      wb_data_r   <= {XLEN{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      req_valid_r <= (state_nxt_s == ST_REQ);
      done_r      <= (state_nxt_s == ST_WB);
      wb_enable_r <= (state_nxt_s == ST_WB) && (accept_s ? wb_cond_s : wb_cond_r);
      if (accept_s) begin
        is_load_r   <= (opcode == OP_LOAD);
        wb_cond_r   <= wb_cond_s;
        func3_r     <= func3;
        offset_r    <= off_s;
        rd_num_r    <= rd_num;
        req_we_r    <= is_store_s;
        req_addr_r  <= {alu_out[XLEN-1:OW], {OW{1'b0}}};
        req_wdata_r <= wdata_s;
        req_be_r    <= size_be_s << off_s;
        wb_data_r   <= alu_out;
      end else if ((state_r == ST_RSP) && dmem_rsp_valid) begin
        wb_data_r <= load_data_s;
      end
    end
  end

`ifdef MEM_WB_MISALIGN_TRAP_EN
  logic misalign_r;

  // A trapped access goes straight from accept to WB, so the flag is set on that edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= accept_s && trap_s;
    end
  end

  assign misalign = misalign_r;
`endif

  load_align #(.XLEN(XLEN), .OW(OW)) u_load_align (
    .rdata  (dmem_rsp_rdata),
    .offset (offset_r),
    .func3  (func3_r),
    .data   (load_data_s)
  );

  assign in_ready       = in_ready_r;
  assign dmem_req_valid = req_valid_r;
  assign dmem_req_we    = req_we_r;
  assign dmem_req_addr  = req_addr_r;
  assign dmem_req_wdata = req_wdata_r;
  assign dmem_req_be    = req_be_r;
  assign wb_enable      = wb_enable_r;
  assign wb_rd_num      = rd_num_r;
  assign wb_rd_data     = wb_data_r;
  assign done           = done_r;

endmodule

// File: tb/tb_mem_wb_unit.sv
// Self-checking bench for mem_wb_unit: directed vector table, random transactions vs. a
// byte-level reference model, reset abandonment and a 64-bit doubleword load.
module tb_mem_wb_unit;
  import mem_wb_pkg::*;

  localparam logic [6:0] OP_ADD = 7'b0110011;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        in_valid, in_ready, wb_reg, dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic        dmem_rsp_valid, wb_enable, done;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [4:0]  rd_num, wb_rd_num;
  logic [31:0] alu_out, rs2_data, dmem_req_addr, dmem_req_wdata, dmem_rsp_rdata, wb_rd_data;
  logic [3:0]  dmem_req_be;
  logic        misalign;

  logic        d_in_valid, d_in_ready, d_wb_reg, d_req_valid, d_req_ready, d_req_we;
  logic        d_rsp_valid, d_wb_enable, d_done;
  logic [6:0]  d_opcode;
  logic [2:0]  d_func3;
  logic [4:0]  d_rd_num, d_wb_rd_num;
  logic [63:0] d_alu_out, d_rs2_data, d_req_addr, d_req_wdata, d_rsp_rdata, d_wb_rd_data;
  logic [7:0]  d_req_be;
  logic        d_misalign;

  mem_wb_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .func3(func3), .wb_reg(wb_reg), .rd_num(rd_num), .alu_out(alu_out), .rs2_data(rs2_data),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_req_we(dmem_req_we),
    .dmem_req_addr(dmem_req_addr), .dmem_req_wdata(dmem_req_wdata), .dmem_req_be(dmem_req_be),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata), .wb_enable(wb_enable),
    .wb_rd_num(wb_rd_num), .wb_rd_data(wb_rd_data), .done(done)
`ifdef MEM_WB_MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  mem_wb_unit #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .opcode(d_opcode),
    .func3(d_func3), .wb_reg(d_wb_reg), .rd_num(d_rd_num), .alu_out(d_alu_out),
    .rs2_data(d_rs2_data), .dmem_req_valid(d_req_valid), .dmem_req_ready(d_req_ready),
    .dmem_req_we(d_req_we), .dmem_req_addr(d_req_addr), .dmem_req_wdata(d_req_wdata),
    .dmem_req_be(d_req_be), .dmem_rsp_valid(d_rsp_valid), .dmem_rsp_rdata(d_rsp_rdata),
    .wb_enable(d_wb_enable), .wb_rd_num(d_wb_rd_num), .wb_rd_data(d_wb_rd_data), .done(d_done)
`ifdef MEM_WB_MISALIGN_TRAP_EN
    , .misalign(d_misalign)
`endif
  );

`ifndef MEM_WB_MISALIGN_TRAP_EN
  assign misalign   = 1'b0;
  assign d_misalign = 1'b0;
`endif

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        wbr;
    logic [4:0]  rd;
    logic [31:0] alu, rs2, rdata;
    int          req_wait, rsp_wait;
    logic        e_mem, e_we, e_wb_en, e_mis;
    logic [31:0] e_addr, e_wdata, e_data;
    logic [3:0]  e_be;
  } vec_t;

  typedef struct {
    logic        req_seen, unstable, ready_bad, done_seen, done_after;
    logic        we, wb_en, mis;
    logic [31:0] addr, wdata, data;
    logic [3:0]  be;
    logic [4:0]  rd;
    int          lat;
  } obs_t;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                              input logic [31:0] alu, rs2, rdata, input int rq, rs,
                              input logic mem, we, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wdata, input logic wben, input logic [31:0] data);
    vec_t v;
    v.op = op; v.f3 = f3; v.wbr = 1'b1; v.rd = rd; v.alu = alu; v.rs2 = rs2; v.rdata = rdata;
    v.req_wait = rq; v.rsp_wait = rs; v.e_mem = mem; v.e_we = we; v.e_addr = addr;
    v.e_be = be; v.e_wdata = wdata; v.e_wb_en = wben; v.e_data = data; v.e_mis = 1'b0;
    return v;
  endfunction

  // Reference behaviour described in terms of bytes and lanes.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    bit is_ld = (v.op == OP_LOAD);
    bit is_st = (v.op == OP_STORE);
    bit mem = is_ld || is_st;
    int size = 1 << v.f3[1:0];
    bit legal = is_ld ? (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (v.f3 inside {3'd0, 3'd1, 3'd2});
    int off = v.alu % 4;
    bit trap = 1'b0;
    bit go;
    longint unsigned val, full;
`ifdef MEM_WB_MISALIGN_TRAP_EN
    trap = mem && legal && (off % size != 0);
`else
    off = off - (off % size);
`endif
    go = mem && legal && !trap;
    r.e_mem = go; r.e_we = is_st; r.e_mis = trap;
    r.e_addr = (v.alu / 4) * 4;
    for (int i = 0; i < 4; i++) begin
      r.e_be[i] = (i >= off) && (i < off + size);
      r.e_wdata[8*i +: 8] = v.rs2[8*(i % size) +: 8];
    end
    val = v.rdata;
    val = val >> (8 * off);
    full = 64'd1 << (8 * size);
    val = val % full;
    if (!v.f3[2] && size < 4 && val >= full / 2) val = val + (64'h1_0000_0000 - full);
    r.e_wb_en = v.wbr && (v.rd != 0) && !is_st && !(mem && !legal) && !trap;
    r.e_data = (is_ld && go) ? val[31:0] : v.alu;
    return r;
  endfunction

  task automatic run_txn(input vec_t v, input bit junk, output obs_t o);
    int req_cnt = 0, rsp_cnt = 0;
    bit hs = 1'b0;
    o = '{default: '0};
    @(posedge clk); #1;
    in_valid = 1'b1; opcode = v.op; func3 = v.f3; wb_reg = v.wbr; rd_num = v.rd;
    alu_out = v.alu; rs2_data = v.rs2;
    @(posedge clk); #1;
    in_valid = 1'b0; opcode = 7'($urandom); func3 = 3'($urandom); rd_num = 5'($urandom);
    alu_out = $urandom; rs2_data = $urandom; wb_reg = 1'($urandom);
    for (int c = 1; c <= 60 && !o.done_seen; c++) begin
      @(negedge clk);
      if (in_ready) o.ready_bad = 1'b1;
      if (dmem_req_valid) begin
        if (!o.req_seen) begin
          o.addr = dmem_req_addr; o.we = dmem_req_we; o.be = dmem_req_be; o.wdata = dmem_req_wdata;
        end else if (o.addr !== dmem_req_addr || o.we !== dmem_req_we || o.be !== dmem_req_be ||
                     o.wdata !== dmem_req_wdata) begin
          o.unstable = 1'b1;
        end
        o.req_seen = 1'b1;
        dmem_req_ready = (req_cnt >= v.req_wait);
        if (dmem_req_ready) hs = 1'b1;
        req_cnt++;
        dmem_rsp_valid = junk;
        dmem_rsp_rdata = $urandom;
      end else begin
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = hs && (rsp_cnt >= v.rsp_wait);
        dmem_rsp_rdata = dmem_rsp_valid ? v.rdata : $urandom;
        if (hs) rsp_cnt++;
      end
      if (done) begin
        o.done_seen = 1'b1; o.lat = c; o.wb_en = wb_enable; o.rd = wb_rd_num;
        o.data = wb_rd_data; o.mis = misalign;
      end
    end
    @(negedge clk);
    o.done_after = done;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
  endtask

  task automatic apply(input vec_t v, input string tag, input bit junk);
    obs_t o;
    int lat;
    run_txn(v, junk, o);
    lat = 1 + (v.e_mem ? 1 + v.req_wait : 0) + ((v.e_mem && !v.e_we) ? 1 + v.rsp_wait : 0);
    check({tag, ".done"}, 64'(o.done_seen), 64'd1);
    check({tag, ".latency"}, 64'(o.lat), 64'(lat));
    check({tag, ".req_seen"}, 64'(o.req_seen), 64'(v.e_mem));
    if (v.e_mem) begin
      check({tag, ".addr"}, 64'(o.addr), 64'(v.e_addr));
      check({tag, ".we"}, 64'(o.we), 64'(v.e_we));
      check({tag, ".stable"}, 64'(o.unstable), 64'd0);
      if (v.e_we) begin
        check({tag, ".be"}, 64'(o.be), 64'(v.e_be));
        check({tag, ".wdata"}, 64'(o.wdata), 64'(v.e_wdata));
      end
    end
    check({tag, ".wb_enable"}, 64'(o.wb_en), 64'(v.e_wb_en));
    check({tag, ".wb_rd_num"}, 64'(o.rd), 64'(v.rd));
    if (!v.e_mis) check({tag, ".wb_rd_data"}, 64'(o.data), 64'(v.e_data));
    check({tag, ".misalign"}, 64'(o.mis), 64'(v.e_mis));
    check({tag, ".done_pulse"}, 64'(o.done_after), 64'd0);
    check({tag, ".in_ready_busy"}, 64'(o.ready_bad), 64'd0);
  endtask

  vec_t tbl[12];

  initial begin
    vec_t v;
    bit bad;
    int kind;
    rst = 1'b0;
    in_valid = 1'b0; opcode = 7'd0; func3 = 3'd0; wb_reg = 1'b0; rd_num = 5'd0;
    alu_out = 32'd0; rs2_data = 32'd0; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = 32'd0;
    d_in_valid = 1'b0; d_opcode = 7'd0; d_func3 = 3'd0; d_wb_reg = 1'b0; d_rd_num = 5'd0;
    d_alu_out = 64'd0; d_rs2_data = 64'd0; d_req_ready = 1'b0; d_rsp_valid = 1'b0;
    d_rsp_rdata = 64'd0;

    tbl[0]  = mk(OP_ADD, 3'd0, 5'd5, 32'd3, 32'd0, 32'd0, 0, 0,
                 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b1, 32'd3);
    tbl[1]  = mk(OP_LOAD, F3_B, 5'd7, 32'h1003, 32'd0, 32'h80FF_FFFF, 0, 0,
                 1'b1, 1'b0, 32'h1000, 4'd0, 32'd0, 1'b1, 32'hFFFF_FF80);
    tbl[2]  = mk(OP_LOAD, F3_BU, 5'd7, 32'h1003, 32'd0, 32'h80FF_FFFF, 0, 0,
                 1'b1, 1'b0, 32'h1000, 4'd0, 32'd0, 1'b1, 32'h0000_0080);
    tbl[3]  = mk(OP_STORE, F3_H, 5'd9, 32'h2002, 32'h1234_ABCD, 32'd0, 0, 0,
                 1'b1, 1'b1, 32'h2000, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h2002);
    tbl[4]  = mk(OP_LOAD, F3_W, 5'd10, 32'h3001, 32'd0, 32'hDEAD_BEEF, 0, 0,
                 1'b1, 1'b0, 32'h3000, 4'd0, 32'd0, 1'b1, 32'hDEAD_BEEF);
`ifdef MEM_WB_MISALIGN_TRAP_EN
    tbl[4].e_mem = 1'b0; tbl[4].e_wb_en = 1'b0; tbl[4].e_mis = 1'b1;
`endif
    tbl[5]  = mk(OP_LOAD, F3_H, 5'd11, 32'h0042, 32'd0, 32'h8001_1234, 1, 1,
                 1'b1, 1'b0, 32'h0040, 4'd0, 32'd0, 1'b1, 32'hFFFF_8001);
    tbl[6]  = mk(OP_LOAD, F3_HU, 5'd11, 32'h0042, 32'd0, 32'h8001_1234, 0, 2,
                 1'b1, 1'b0, 32'h0040, 4'd0, 32'd0, 1'b1, 32'h0000_8001);
    tbl[7]  = mk(OP_STORE, F3_B, 5'd12, 32'h5001, 32'h1234_56AA, 32'd0, 0, 0,
                 1'b1, 1'b1, 32'h5000, 4'b0010, 32'hAAAA_AAAA, 1'b0, 32'h5001);
    tbl[8]  = mk(OP_STORE, F3_W, 5'd13, 32'h6000, 32'h1122_3344, 32'd0, 5, 0,
                 1'b1, 1'b1, 32'h6000, 4'b1111, 32'h1122_3344, 1'b0, 32'h6000);
    tbl[9]  = mk(OP_LOAD, F3_WU, 5'd3, 32'h7000, 32'd0, 32'hFFFF_FFFF, 0, 0,
                 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 32'h7000);
    tbl[10] = mk(OP_ADD, 3'd0, 5'd0, 32'h55, 32'd0, 32'd0, 0, 0,
                 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 32'h55);
    tbl[11] = mk(OP_LOAD, F3_W, 5'd31, 32'h0100, 32'd0, 32'h7FFF_0001, 2, 3,
                 1'b1, 1'b0, 32'h0100, 4'd0, 32'd0, 1'b1, 32'h7FFF_0001);

    repeat (2) @(negedge clk);
    check("reset.in_ready", 64'(in_ready), 64'd1);
    check("reset.req_valid", 64'(dmem_req_valid), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.wb_enable", 64'(wb_enable), 64'd0);
    check("reset.wb_rd_data", 64'(wb_rd_data), 64'd0);
    check("reset.misalign", 64'(misalign), 64'd0);
    @(posedge clk); #1 rst = 1'b1;

    for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("vec%0d", i), 1'(i % 2));

    for (int n = 0; n < 40; n++) begin
      v = mk(OP_ADD, 3'd0, 5'($urandom), $urandom, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3),
             1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 32'd0);
      v.wbr = 1'($urandom);
      kind = $urandom_range(0, 2);
      if (kind == 1) begin
        v.op = OP_LOAD; v.f3 = 3'($urandom_range(0, 6));
      end else if (kind == 2) begin
        v.op = OP_STORE; v.f3 = 3'($urandom_range(0, 3));
      end else begin
        v.op = ($urandom_range(0, 1) == 0) ? OP_ADD : 7'b0010011; v.f3 = 3'($urandom);
      end
      apply(model(v), $sformatf("rnd%0d", n), 1'($urandom));
    end

    // Reset while waiting for a load response abandons the transaction.
    @(posedge clk); #1;
    in_valid = 1'b1; opcode = OP_LOAD; func3 = F3_W; wb_reg = 1'b1; rd_num = 5'd4; alu_out = 32'h900;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("rst_mid.req_valid", 64'(dmem_req_valid), 64'd1);
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    check("rst_mid.in_rsp_no_req", 64'(dmem_req_valid), 64'd0);
    #2 rst = 1'b0;
    #1;
    check("rst_mid.in_ready", 64'(in_ready), 64'd1);
    check("rst_mid.wb_rd_data", 64'(wb_rd_data), 64'd0);
    check("rst_mid.done", 64'(done), 64'd0);
    @(posedge clk); #1 rst = 1'b1;
    dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'hCAFE_F00D;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done || dmem_req_valid || wb_enable || !in_ready) bad = 1'b1;
    end
    dmem_rsp_valid = 1'b0;
    check("rst_mid.late_rsp_ignored", 64'(bad), 64'd0);

    // Doubleword load on the 64-bit datapath.
    @(posedge clk); #1;
    d_in_valid = 1'b1; d_opcode = OP_LOAD; d_func3 = F3_D; d_wb_reg = 1'b1; d_rd_num = 5'd8;
    d_alu_out = 64'h8;
    @(posedge clk); #1 d_in_valid = 1'b0;
    @(negedge clk);
    check("ld64.req_valid", 64'(d_req_valid), 64'd1);
    check("ld64.be", 64'(d_req_be), 64'hFF);
    check("ld64.addr", d_req_addr, 64'h8);
    d_req_ready = 1'b1;
    @(negedge clk);
    d_req_ready = 1'b0; d_rsp_valid = 1'b1; d_rsp_rdata = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    d_rsp_valid = 1'b0;
    check("ld64.done", 64'(d_done), 64'd1);
    check("ld64.wb_enable", 64'(d_wb_enable), 64'd1);
    check("ld64.data", d_wb_rd_data, 64'h0123_4567_89AB_CDEF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_wb_unit.md
MEM_WB_UNIT -- requirements
Module: mem_wb_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter NB = XLEN/8 (derived, not overridable), byte lanes per word.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  unit can accept an instruction.
- opcode  in  7  RISC-V opcode.
- func3  in  3  access size/sign.
- wb_reg  in  1  instruction writes rd.
- rd_num  in  5  destination register.
- alu_out  in  XLEN  result or effective address.
- rs2_data  in  XLEN  store data.
- dmem_req_valid  out  1  memory request valid.
- dmem_req_ready  in  1  memory accepts request.
- dmem_req_we  out  1  1 = store.
- dmem_req_addr  out  XLEN  word-aligned address.
- dmem_req_wdata  out  XLEN  lane-replicated store data.
- dmem_req_be  out  NB  byte enables.
- dmem_rsp_valid  in  1  load data valid.
- dmem_rsp_rdata  in  XLEN  load word.
- wb_enable  out  1  regfile write strobe.
- wb_rd_num  out  5  regfile address.
- wb_rd_data  out  XLEN  regfile data.
- done  out  1  one-cycle completion pulse.
- misalign  out  1  misaligned access flag (MEM_WB_MISALIGN_TRAP_EN only).

Function
REQ-004 SHALL implement FSM IDLE, REQ, RSP, WB; in_ready = 1 only in IDLE.
REQ-005 SHALL, on in_valid && in_ready, latch all inputs; LOAD (0000011) or STORE (0100011) -> REQ, any other opcode -> WB.
REQ-006 SHALL, in REQ, hold dmem_req_valid = 1 with stable addr/we/wdata/be until dmem_req_ready = 1; then LOAD -> RSP, STORE -> WB.
REQ-007 SHALL, in RSP, wait indefinitely for dmem_rsp_valid, register the extracted load value, then -> WB; dmem_rsp_valid outside RSP SHALL be ignored.
REQ-008 SHALL, in WB, assert done for exactly one cycle and return to IDLE; minimum latencies: ALU op 2 cycles, store 3, load 4 (accept to done, zero memory wait).
REQ-009 SHALL drive wb_enable = latched wb_reg && rd_num != 0 && opcode != STORE, only in WB; wb_rd_num = latched rd_num.
REQ-010 SHALL drive wb_rd_data = latched alu_out for non-loads, extracted load value for loads.
REQ-011 SHALL form dmem_req_addr = alu_out with low log2(NB) bits cleared; offset = those low bits.
REQ-012 SHALL extract loads by shifting rdata right by offset*8, then extending: LB/LH/LW sign, LBU/LHU/LWU zero, LD (XLEN=64) none.
REQ-013 SHALL generate store be = size mask (SB 1, SH 2, SW 4, SD 8 bytes) shifted left by offset, and wdata = rs2 low bytes replicated across all lanes.
REQ-014 SHALL treat func3 LWU/LD/SD as illegal when XLEN=32: ALU-style completion, no memory access, wb_enable = 0.
REQ-015 SHALL, without the trap feature, align misaligned accesses down to access size (offset low bits cleared).

Reset
REQ-016 SHALL, on rst = 0, asynchronously enter IDLE and clear dmem_req_valid, wb_enable, done, misalign, and all datapath registers to 0; reset mid-transaction abandons it with no further request.

Configuration
REQ-017 SHALL, with MEM_WB_MISALIGN_TRAP_EN defined, route misaligned loads/stores from IDLE directly to WB with no memory request, wb_enable = 0, misalign = 1 together with done.
REQ-018 SHALL, without MEM_WB_MISALIGN_TRAP_EN, omit the misalign port and behave per REQ-015.

Structure
REQ-019 SHALL place opcode constants, func3 encodings and the FSM state enum in shared package mem_wb_pkg.
REQ-020 SHALL implement load extraction/extension as combinational sub-module load_align.

Verification
REQ-021 ADD x5=3 (opcode 0110011, rd 5, alu_out 3) -> done and wb_enable two cycles after accept, wb_rd_data 3.
REQ-022 LB at 0x1003, rdata 0x80FF_FFFF, XLEN=32 -> req addr 0x1000, wb_rd_data 0xFFFF_FF80; LBU -> 0x0000_0080.
REQ-023 SH at 0x2002, rs2 0x1234_ABCD -> be 4'b1100, wdata 0xABCD_ABCD, we 1, wb_enable 0.
REQ-024 dmem_req_ready low 5 cycles -> request fields stable throughout, in_ready 0, done one cycle after ready+WB.
REQ-025 LW at 0x3001 with MEM_WB_MISALIGN_TRAP_EN -> no dmem_req_valid, misalign 1 with done; without macro -> addr 0x3000.
REQ-026 rst low during RSP -> IDLE immediately, later dmem_rsp_valid ignored, XLEN=64 LD at 0x8 -> be 8'hFF.
